win_scan_controller: RTL and testbench

//  Sequences direction_checker after each placed piece: builds the set of the 13 line directions that

---
 rtl/conn4_pkg.sv | 23 ++
 rtl/win_scan_controller_if.sv | 11 +
 rtl/win_dir_mask.sv | 23 ++
 rtl/win_scan_controller.sv | 102 ++++++++++
 tb/tb_win_scan_controller.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/conn4_pkg.sv
// conn4_pkg: direction codes, scan states and per-direction row/column offset tables
package conn4_pkg;
  localparam int ROWS_DEF = 6;
  localparam int COLS_DEF = 7;
  localparam int NDIR = 13;
  typedef enum logic [2:0] {S_IDLE, S_MASK, S_SELECT, S_START, S_WAIT, S_FIN} state_t;
  typedef enum logic [3:0] {
    DIR_NONE, DIR_DOWN,
    DIR_ROW_1, DIR_ROW_2, DIR_ROW_3, DIR_ROW_4,
    DIR_DRU_1, DIR_DRU_2, DIR_DRU_3, DIR_DRU_4,
    DIR_DLD_1, DIR_DLD_2, DIR_DLD_3, DIR_DLD_4
  } dir_t;
  typedef logic signed [4:0] off_t;
  // Index is direction code minus one
  localparam off_t RMIN [NDIR] = '{-5'sd3, 5'sd0, 5'sd0, 5'sd0, 5'sd0,
                                   -5'sd3, -5'sd2, -5'sd1, 5'sd0, -5'sd3, -5'sd2, -5'sd1, 5'sd0};
  localparam off_t RMAX [NDIR] = '{5'sd0, 5'sd0, 5'sd0, 5'sd0, 5'sd0,
                                   5'sd0, 5'sd1, 5'sd2, 5'sd3, 5'sd0, 5'sd1, 5'sd2, 5'sd3};
  localparam off_t CMIN [NDIR] = '{5'sd0, -5'sd3, -5'sd2, -5'sd1, 5'sd0,
                                   -5'sd3, -5'sd2, -5'sd1, 5'sd0, 5'sd0, -5'sd1, -5'sd2, -5'sd3};
  localparam off_t CMAX [NDIR] = '{5'sd0, 5'sd0, 5'sd1, 5'sd2, 5'sd3,
                                   5'sd0, 5'sd1, 5'sd2, 5'sd3, 5'sd3, 5'sd2, 5'sd1, 5'sd0};
endpackage

// File: rtl/win_scan_controller_if.sv
// win_scan_controller_if: start/finish handshake between the scan controller and direction_checker
interface win_scan_controller_if;
  logic       chk_start;
  logic [2:0] chk_row;
  logic [2:0] chk_col;
  logic [3:0] chk_direction;
  logic       chk_finished;
  logic [1:0] chk_winner;
  modport master(output chk_start, chk_row, chk_col, chk_direction, input chk_finished, chk_winner);
  modport slave(input chk_start, chk_row, chk_col, chk_direction, output chk_finished, chk_winner);
endinterface

// File: rtl/win_dir_mask.sv
// win_dir_mask: which of the 13 line directions through (row,col) stay fully on the board
module win_dir_mask
  import conn4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [2:0]      row,
  input  logic [2:0]      col,
  output logic [NDIR-1:0] mask,
  output logic            in_range
);
  localparam off_t RL = off_t'(ROWS - 1);
  localparam off_t CL = off_t'(COLS - 1);
  off_t r, c;
  assign r = $signed({2'b00, row});
  assign c = $signed({2'b00, col});
  assign in_range = (r <= RL) && (c <= CL);
  for (genvar d = 0; d < NDIR; d++) begin : g_dir
    assign mask[d] = (r + RMIN[d] >= 5'sd0) && (r + RMAX[d] <= RL) &&
                     (c + CMIN[d] >= 5'sd0) && (c + CMAX[d] <= CL);
  end
endmodule

// File: rtl/win_scan_controller.sv
// win_scan_controller: runs direction_checker over every on-board direction of a new piece,
// stopping at the first non-zero winner or on a checker timeout
module win_scan_controller
  import conn4_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   move_valid,
  input  logic [2:0]             move_row,
  input  logic [2:0]             move_col,
  output logic                   move_ready,
  win_scan_controller_if.master  chk,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             winner,
  output logic [3:0]             win_dir,
  output logic                   err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [3:0] dir_q, dir_d, win_dir_q, win_dir_d, sel;
  logic [NDIR-1:0] mask_q, mask_d, mask_c;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0] winner_q, winner_d;
  logic err_q, err_d, in_range, timeout, accept, fin_win, tmo;
  win_dir_mask #(.ROWS(ROWS), .COLS(COLS)) u_mask (
    .row(row_q), .col(col_q), .mask(mask_c), .in_range(in_range)
  );
  always_comb begin
    sel = DIR_NONE;
    for (int i = NDIR - 1; i >= 0; i--) if (mask_q[i]) sel = 4'(i + 1);
  end
  assign timeout = timer_q == TW'(TIMEOUT - 1);
  assign accept  = state_q == S_IDLE && move_valid;
  assign fin_win = state_q == S_WAIT && chk.chk_finished && chk.chk_winner != 2'b00;
  assign tmo     = state_q == S_WAIT && !chk.chk_finished && timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (move_valid) state_d = S_MASK;
      S_MASK:   state_d = in_range ? S_SELECT : S_FIN;
      S_SELECT: state_d = mask_q == '0 ? S_FIN : S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (chk.chk_finished) state_d = chk.chk_winner != 2'b00 ? S_FIN : S_SELECT;
                else if (timeout) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    move_ready        = state_q == S_IDLE;
    busy              = state_q != S_IDLE;
    done              = state_q == S_FIN;
    chk.chk_start     = state_q == S_START;
    chk.chk_direction = state_q == S_IDLE ? DIR_NONE : dir_q;
    chk.chk_row       = row_q;
    chk.chk_col       = col_q;
    winner            = winner_q;
    win_dir           = win_dir_q;
    err               = err_q;
  end
  // Picking a direction clears its bit by dropping the lowest set bit of the mask
  always_comb begin
    row_d     = accept ? move_row : row_q;
    col_d     = accept ? move_col : col_q;
    mask_d    = state_q == S_MASK ? (in_range ? mask_c : '0) :
                state_q == S_SELECT ? mask_q & (mask_q - NDIR'(1)) : mask_q;
    dir_d     = state_q == S_SELECT ? sel : dir_q;
    timer_d   = state_q == S_START ? '0 : state_q == S_WAIT ? timer_q + TW'(1) : timer_q;
    winner_d  = (accept || tmo) ? 2'b00 : fin_win ? chk.chk_winner : winner_q;
    win_dir_d = accept ? DIR_NONE : fin_win ? dir_q : win_dir_q;
    err_d     = accept ? 1'b0 : ((state_q == S_MASK && !in_range) || tmo) ? 1'b1 : err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      mask_q    <= '0;
      dir_q     <= '0;
      timer_q   <= '0;
      winner_q  <= '0;
      win_dir_q <= '0;
      err_q     <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      mask_q    <= mask_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      winner_q  <= winner_d;
      win_dir_q <= win_dir_d;
      err_q     <= err_d;
    end
endmodule

// File: tb/tb_win_scan_controller.sv
// tb_win_scan_controller: directed scans against a stub checker with per-direction winners
module tb_win_scan_controller;
  localparam int TIMEOUT = 15;
  logic clk = 0, rst_n = 0, move_valid = 0;
  logic [2:0] move_row = 0, move_col = 0;
  logic move_ready, busy, done, err;
  logic [1:0] winner;
  logic [3:0] win_dir;
  win_scan_controller_if chk();
  win_scan_controller #(.ROWS(6), .COLS(7), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_row(move_row), .move_col(move_col),
    .move_ready(move_ready), .chk(chk), .busy(busy), .done(done), .winner(winner),
    .win_dir(win_dir), .err(err)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0, first_start = -1, drive_cyc = 0;
  int lat = 2, pend = 0;
  bit respond = 1;
  logic [1:0] win_tab [16];
  logic fin = 0;
  logic [1:0] win = 2'b11;
  int starts[$];
  int q[$];
  assign chk.chk_finished = fin;
  assign chk.chk_winner = win;
  // Stub checker: answers lat cycles after each start, result looked up per direction
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    fin = 1'b0;
    win = 2'b11;
    if (chk.chk_start) begin
      starts.push_back(int'(chk.chk_direction));
      if (first_start < 0) first_start = cyc;
      pend = lat;
    end else if (pend > 0) begin
      if (pend == 1 && respond) begin
        fin = 1'b1;
        win = win_tab[chk.chk_direction];
      end
      pend = pend - 1;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic do_move(input int r, input int c);
    int n = 0;
    int d0;
    starts.delete();
    first_start = -1;
    d0 = done_cnt;
    while (!move_ready && n < 50) begin
      tick();
      n++;
    end
    move_row = 3'(r);
    move_col = 3'(c);
    move_valid = 1;
    drive_cyc = cyc;
    tick();
    move_valid = 0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    check($sformatf("done_pulses_%0d_%0d", r, c), done_cnt - d0, 1);
  endtask
  task automatic check_list(input string tag, input int exp[$]);
    check({tag, "_starts"}, starts.size(), exp.size());
    foreach (exp[i]) check($sformatf("%s_dir%0d", tag, i), i < starts.size() ? starts[i] : -1, exp[i]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, d0;
    foreach (win_tab[i]) win_tab[i] = 2'b00;
    tick();
    tick();
    check("rst_move_ready", move_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_winner", winner, 0);
    check("rst_win_dir", win_dir, 0);
    check("rst_err", err, 0);
    check("rst_chk_start", chk.chk_start, 0);
    check("rst_chk_dir", chk.chk_direction, 0);
    rst_n = 1;
    tick();
    do_move(2, 3);
    q = '{2, 3, 4, 5, 7, 8, 9, 11, 12, 13};
    check_list("m23", q);
    check("m23_winner", winner, 0);
    check("m23_err", err, 0);
    check("idle_chk_dir", chk.chk_direction, 0);
    do_move(0, 0);
    q = '{5, 9};
    check_list("m00", q);
    check("m00_winner", winner, 0);
    win_tab[1] = 2'b01;
    do_move(3, 4);
    q = '{1};
    check_list("m34", q);
    check("m34_winner", winner, 1);
    check("m34_win_dir", win_dir, 1);
    check("m34_err", err, 0);
    win_tab[1] = 2'b00;
    win_tab[4] = 2'b10;
    do_move(2, 3);
    q = '{2, 3, 4};
    check_list("m23w", q);
    check("m23w_winner", winner, 2);
    check("m23w_win_dir", win_dir, 4);
    win_tab[4] = 2'b00;
    do_move(6, 2);
    check("m62_starts", starts.size(), 0);
    check("m62_err", err, 1);
    check("m62_winner", winner, 0);
    check("m62_win_dir", win_dir, 0);
    check("m62_done_lat", done_cyc - drive_cyc, 2);
    do_move(3, 7);
    check("m37_starts", starts.size(), 0);
    check("m37_err", err, 1);
    respond = 0;
    do_move(3, 4);
    check("tmo_starts", starts.size(), 1);
    check("tmo_done_lat", done_cyc - first_start, TIMEOUT + 1);
    check("tmo_err", err, 1);
    check("tmo_winner", winner, 0);
    respond = 1;
    lat = 8;
    starts.delete();
    while (!move_ready) tick();
    move_row = 3;
    move_col = 3;
    move_valid = 1;
    tick();
    move_valid = 0;
    n = 0;
    while (starts.size() < 4 && n < 200) begin
      tick();
      n++;
    end
    check("rstmid_dir4", starts.size() >= 4 ? starts[3] : -1, 4);
    tick();
    d0 = done_cnt;
    rst_n = 0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_chk_start", chk.chk_start, 0);
    check("rstmid_move_ready", move_ready, 1);
    check("rstmid_chk_dir", chk.chk_direction, 0);
    repeat (3) tick();
    check("rstmid_no_done", done_cnt - d0, 0);
    rst_n = 1;
    lat = 2;
    tick();
    do_move(3, 3);
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12};
    check_list("m33", q);
    check("m33_winner", winner, 0);
    check("m33_err", err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
